// File: rtl/spi_mem_ctrl_if.sv
// Request port from the CPU control FSM plus the SPI pins of the serial SRAM,
// bundled so the memory controller and its environment share one connection.
interface spi_mem_ctrl_if #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_BUS_WIDTH = 8
);
  logic [1:0]                mem_ctrl_op;
  logic [ADDR_WIDTH-1:0]     addr;
  logic [DATA_BUS_WIDTH-1:0] data_in;
  logic [DATA_BUS_WIDTH-1:0] data_out;
  logic                      mem_op_done;
  logic                      spi_cs_n;
  logic                      spi_sclk;
  logic                      spi_mosi;
  logic                      spi_miso;

  modport slave (
    input  mem_ctrl_op, addr, data_in, spi_miso,
    output data_out, mem_op_done, spi_cs_n, spi_sclk, spi_mosi
  );

  modport master (
    output mem_ctrl_op, addr, data_in, spi_miso,
    input  data_out, mem_op_done, spi_cs_n, spi_sclk, spi_mosi
  );
endinterface

// File: rtl/spi_mem_ctrl.sv
// Executes single-byte MEM_READ/MEM_WRITE requests against a 23LC-style serial SRAM
// over SPI mode 0, returning the read byte and a one-cycle completion strobe.
module spi_mem_ctrl #(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int ADDR_WIDTH     = 16,
  parameter int SCLK_HALF      = 1
) (
  input logic           clock,
  input logic           reset,
  spi_mem_ctrl_if.slave bus
);
  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam int FRAME_W = 24 + DATA_BUS_WIDTH;
  localparam int BC_W    = $clog2(FRAME_W);
  localparam int PW      = $clog2(2 * SCLK_HALF) + 1;
  localparam logic [PW-1:0]   PH_RISE = PW'(SCLK_HALF - 1);
  localparam logic [PW-1:0]   PH_FALL = PW'(2 * SCLK_HALF - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(FRAME_W - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE, RELEASE} state_e;

  state_e                    state, state_nx;
  logic [FRAME_W-1:0]        frame, frame_new;
  logic [DATA_BUS_WIDTH-1:0] rx, dout;
  logic [BC_W-1:0]           bit_cnt;
  logic [PW-1:0]             phase;
  logic                      is_read;
  logic                      cs_n_q, sclk_q, mosi_q, done_q;
  logic                      cs_n_d, sclk_d, mosi_d, done_d;
  logic [15:0]               addr_ext;
  logic                      req_rd, req_wr, rise, fall, last_bit;

  assign req_rd    = (bus.mem_ctrl_op == MEM_READ);
  assign req_wr    = (bus.mem_ctrl_op == MEM_WRITE);
  assign addr_ext  = 16'(bus.addr);
  assign frame_new = {req_rd ? CMD_READ : CMD_WRITE, addr_ext, req_rd ? '0 : bus.data_in};
  assign rise      = (state == SHIFT) && (phase == PH_RISE);
  assign fall      = (state == SHIFT) && (phase == PH_FALL);
  assign last_bit  = (bit_cnt == BC_LAST);

  // Output values are computed for the state being entered, then registered.
  always_comb begin
    state_nx = state;
    cs_n_d   = cs_n_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    done_d   = 1'b0;
    case (state)
      IDLE: begin
        if (req_rd || req_wr) begin
          state_nx = SETUP;
          cs_n_d   = 1'b0;
          mosi_d   = frame_new[FRAME_W-1];
        end
      end
      SETUP: state_nx = SHIFT;
      SHIFT: begin
        if (rise) sclk_d = 1'b1;
        if (fall) begin
          sclk_d = 1'b0;
          mosi_d = frame[FRAME_W-2];
          if (last_bit) begin
            state_nx = HOLD;
            mosi_d   = 1'b0;
          end
        end
      end
      HOLD: begin
        state_nx = DONE;
        cs_n_d   = 1'b1;
        done_d   = 1'b1;
      end
      DONE: state_nx = RELEASE;
      RELEASE: begin
        if (!(req_rd || req_wr)) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cs_n_d   = 1'b1;
        sclk_d   = 1'b0;
        mosi_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cs_n_q <= 1'b1;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cs_n_q <= cs_n_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      done_q <= done_d;
    end
  end

  // Frame shifts out on SCLK falls; MISO is captured on the cycle SCLK rises.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame   <= '0;
      rx      <= '0;
      dout    <= '0;
      bit_cnt <= '0;
      phase   <= '0;
      is_read <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_rd || req_wr) begin
            frame   <= frame_new;
            is_read <= req_rd;
            bit_cnt <= '0;
            phase   <= '0;
          end
        end
        SHIFT: begin
          if (rise) rx <= {rx[DATA_BUS_WIDTH-2:0], bus.spi_miso};
          if (fall) begin
            phase   <= '0;
            frame   <= {frame[FRAME_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + BC_W'(1);
          end else begin
            phase <= phase + PW'(1);
          end
        end
        HOLD: begin
          if (is_read) dout <= rx;
        end
        default: ;
      endcase
    end
  end

  assign bus.spi_cs_n    = cs_n_q;
  assign bus.spi_sclk    = sclk_q;
  assign bus.spi_mosi    = mosi_q;
  assign bus.mem_op_done = done_q;
  assign bus.data_out    = dout;
endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Bench for spi_mem_ctrl: two instances (default timing, and SCLK_HALF=3 with 8-bit address),
// each talking to a behavioural serial SRAM, checked against table vectors and a reference model.
module tb_spi_mem_ctrl;
  localparam logic [1:0] NOP = 2'd0, RD = 2'd1, WR = 2'd2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  spi_mem_ctrl_if #(.ADDR_WIDTH(16), .DATA_BUS_WIDTH(8)) i1 ();
  spi_mem_ctrl_if #(.ADDR_WIDTH(8),  .DATA_BUS_WIDTH(8)) i2 ();

  spi_mem_ctrl #(.DATA_BUS_WIDTH(8), .ADDR_WIDTH(16), .SCLK_HALF(1)) u1 (
    .clock(clock), .reset(reset), .bus(i1.slave));
  spi_mem_ctrl #(.DATA_BUS_WIDTH(8), .ADDR_WIDTH(8), .SCLK_HALF(3)) u2 (
    .clock(clock), .reset(reset), .bus(i2.slave));

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Behavioural 23LC-style SRAM on instance 1
  logic [7:0]  mem     [65536];
  logic [7:0]  ref_mem [65536];
  logic [7:0]  ref_dout = 8'h00;
  logic [31:0] s_sh = '0, s_last_frame = '0;
  int          s_cnt = 0, s_last_rises = 0, cs_falls = 0;
  logic        s_rd = 1'b0, s_cs_prev = 1'b1, s_sclk_prev = 1'b0;
  logic [7:0]  s_byte = '0;

  always @(i1.spi_cs_n or i1.spi_sclk) begin
    if (s_cs_prev === 1'b1 && i1.spi_cs_n === 1'b0) begin
      s_sh = '0; s_cnt = 0; s_rd = 1'b0; cs_falls++;
    end else if (s_cs_prev === 1'b0 && i1.spi_cs_n === 1'b1) begin
      s_last_frame = s_sh;
      s_last_rises = s_cnt;
      if (s_cnt == 32 && s_sh[31:24] == 8'h02) mem[s_sh[23:8]] = s_sh[7:0];
    end
    if (i1.spi_cs_n === 1'b0 && s_sclk_prev === 1'b0 && i1.spi_sclk === 1'b1) begin
      s_sh = {s_sh[30:0], i1.spi_mosi};
      s_cnt++;
    end
    if (i1.spi_cs_n === 1'b0 && s_sclk_prev === 1'b1 && i1.spi_sclk === 1'b0) begin
      if (s_cnt == 24) begin
        s_rd   = (s_sh[23:16] == 8'h03);
        s_byte = mem[s_sh[15:0]];
      end
      if (s_rd && s_cnt >= 24 && s_cnt < 32) i1.spi_miso = s_byte[31-s_cnt];
    end
    s_cs_prev   = i1.spi_cs_n;
    s_sclk_prev = i1.spi_sclk;
  end

  // Minimal SRAM on instance 2: answers every read with a fixed byte
  logic [31:0] s2_sh = '0, s2_last_frame = '0;
  int          s2_cnt = 0, s2_last_rises = 0;
  logic        s2_cs_prev = 1'b1, s2_sclk_prev = 1'b0;
  logic [7:0]  s2_byte = 8'h5A;
  time         s2_t_last = 0, s2_t_prev = 0;

  always @(i2.spi_cs_n or i2.spi_sclk) begin
    if (s2_cs_prev === 1'b1 && i2.spi_cs_n === 1'b0) begin
      s2_sh = '0; s2_cnt = 0;
    end else if (s2_cs_prev === 1'b0 && i2.spi_cs_n === 1'b1) begin
      s2_last_frame = s2_sh;
      s2_last_rises = s2_cnt;
    end
    if (i2.spi_cs_n === 1'b0 && s2_sclk_prev === 1'b0 && i2.spi_sclk === 1'b1) begin
      s2_sh = {s2_sh[30:0], i2.spi_mosi};
      s2_cnt++;
      s2_t_prev = s2_t_last;
      s2_t_last = $time;
    end
    if (i2.spi_cs_n === 1'b0 && s2_sclk_prev === 1'b1 && i2.spi_sclk === 1'b0)
      if (s2_cnt >= 24 && s2_cnt < 32) i2.spi_miso = s2_byte[31-s2_cnt];
    s2_cs_prev   = i2.spi_cs_n;
    s2_sclk_prev = i2.spi_sclk;
  end

  task automatic run_txn(input logic [1:0] op, input logic [15:0] a, input logic [7:0] d,
                         input int hold, input logic [31:0] exp_frame, input logic [7:0] exp_dout);
    int lat, cs0;
    cs0 = cs_falls;
    @(negedge clock);
    i1.mem_ctrl_op = op; i1.addr = a; i1.data_in = d;
    @(posedge clock);
    lat = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      if (k == 0) begin i1.data_in = ~d; i1.addr = a ^ 16'h00F0; end
      if (i1.mem_op_done === 1'b1) begin lat = k; break; end
    end
    check("latency", 32'(lat), 32'd66);
    check("mosi_frame", s_last_frame, exp_frame);
    check("sclk_rises", 32'(s_last_rises), 32'd32);
    check("data_out", 32'(i1.data_out), 32'(exp_dout));
    if (op == WR) check("sram_write", 32'(mem[a]), 32'(d));
    @(negedge clock);
    check("done_width", 32'(i1.mem_op_done), 32'd0);
    repeat (hold) @(negedge clock);
    check("no_reexec", 32'(cs_falls - cs0), 32'd1);
    i1.mem_ctrl_op = NOP;
    if (op == WR) ref_mem[a] = d;
    ref_dout = exp_dout;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          hold;
    logic [31:0] exp_frame;
    logic [7:0]  exp_dout;
  } vec_t;

  vec_t vt [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        bad;
    int          cs0, lat;
    logic [1:0]  op;
    logic [15:0] a;
    logic [7:0]  d, ed;

    vt[0] = '{RD, 16'h1234, 8'h00, 0,  32'h03123400, 8'hA5};
    vt[1] = '{WR, 16'h00FF, 8'h3C, 0,  32'h0200FF3C, 8'hA5};
    vt[2] = '{RD, 16'h00FF, 8'h00, 10, 32'h0300FF00, 8'h3C};
    vt[3] = '{WR, 16'h1234, 8'h00, 2,  32'h02123400, 8'h3C};
    vt[4] = '{RD, 16'h1234, 8'h00, 0,  32'h03123400, 8'h00};
    vt[5] = '{RD, 16'hFFFF, 8'h00, 1,  32'h03FFFF00, 8'h81};

    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'(i ^ (i >> 8));
      ref_mem[i] = 8'(i ^ (i >> 8));
    end
    mem[16'h1234] = 8'hA5; ref_mem[16'h1234] = 8'hA5;
    mem[16'hFFFF] = 8'h81; ref_mem[16'hFFFF] = 8'h81;

    i1.mem_ctrl_op = NOP; i1.addr = '0; i1.data_in = '0;
    i2.mem_ctrl_op = NOP; i2.addr = '0; i2.data_in = '0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_cs_n", 32'(i1.spi_cs_n), 32'd1);
    check("rst_sclk", 32'(i1.spi_sclk), 32'd0);
    check("rst_done", 32'(i1.mem_op_done), 32'd0);
    check("rst_data_out", 32'(i1.data_out), 32'd0);
    reset = 1'b1;

    // Reset asserted in the middle of a READ shift
    @(negedge clock);
    i1.mem_ctrl_op = RD; i1.addr = 16'h1234;
    repeat (20) @(negedge clock);
    check("abort_in_shift_cs_n", 32'(i1.spi_cs_n), 32'd0);
    i1.mem_ctrl_op = NOP;
    reset = 1'b0;
    #1;
    check("abort_cs_n", 32'(i1.spi_cs_n), 32'd1);
    check("abort_sclk", 32'(i1.spi_sclk), 32'd0);
    check("abort_mosi", 32'(i1.spi_mosi), 32'd0);
    check("abort_done", 32'(i1.mem_op_done), 32'd0);
    check("abort_data_out", 32'(i1.data_out), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    bad = 1'b0;
    repeat (80) begin
      @(negedge clock);
      if (i1.mem_op_done !== 1'b0 || i1.spi_cs_n !== 1'b1) bad = 1'b1;
    end
    check("abort_no_done", 32'(bad), 32'd0);

    // op=3 must behave as NOP
    cs0 = cs_falls;
    bad = 1'b0;
    i1.mem_ctrl_op = 2'd3; i1.addr = 16'h1234;
    repeat (20) begin
      @(negedge clock);
      if (i1.mem_op_done !== 1'b0 || i1.spi_cs_n !== 1'b1) bad = 1'b1;
    end
    i1.mem_ctrl_op = NOP;
    check("op3_idle", 32'(bad), 32'd0);
    check("op3_no_cs", 32'(cs_falls - cs0), 32'd0);

    for (int i = 0; i < 6; i++)
      run_txn(vt[i].op, vt[i].addr, vt[i].wdata, vt[i].hold, vt[i].exp_frame, vt[i].exp_dout);

    // Randomised traffic against the reference memory model
    for (int i = 0; i < 16; i++) begin
      op = ($urandom_range(0, 1) == 0) ? RD : WR;
      a  = 16'h0100 + 16'($urandom_range(0, 3));
      d  = 8'($urandom);
      ed = (op == RD) ? ref_mem[a] : ref_dout;
      run_txn(op, a, d, int'($urandom_range(0, 3)),
              {(op == RD) ? 8'h03 : 8'h02, a, (op == RD) ? 8'h00 : d}, ed);
    end

    // Slow SCLK, 8-bit address instance
    @(negedge clock);
    i2.mem_ctrl_op = RD; i2.addr = 8'h80;
    @(posedge clock);
    lat = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      if (i2.mem_op_done === 1'b1) begin lat = k; break; end
    end
    check("slow_latency", 32'(lat), 32'd194);
    check("slow_frame", s2_last_frame, 32'h03008000);
    check("slow_rises", 32'(s2_last_rises), 32'd32);
    check("slow_sclk_period", 32'(s2_t_last - s2_t_prev), 32'd60);
    check("slow_data_out", 32'(i2.data_out), 32'h5A);
    i2.mem_ctrl_op = NOP;
    repeat (3) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
